// File: rtl/minialu_pkg.sv
// Shared constants and types for the miniALU result-to-BCD converter.
// Optional feature macro: RESULT_SIGNED_EN (two's-complement input, adds neg).
package minialu_pkg;

  localparam int RESULT_W   = 20;
  localparam int BCD_DIGITS = 7;
  localparam int BCD_W      = BCD_DIGITS * 4;
  localparam int CNT_W      = 5;

  typedef logic [3:0]          digit_t;
  typedef logic [CNT_W-1:0]    cnt_t;
  typedef logic [RESULT_W-1:0] result_t;
  typedef logic [BCD_W-1:0]    bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter value on the last of the RESULT_W shift cycles.
  localparam cnt_t LAST_SHIFT = cnt_t'(RESULT_W - 1);

  // Double-dabble digit correction: a digit of 5..9 would become >= 10
  // after the next doubling, so pre-add 3 to carry into the next digit.
  function automatic digit_t add3_if_ge5(input digit_t d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/result_bcd_conv_if.sv
// Handshake bundle between a miniALU producer/consumer and result_bcd_conv.
// Optional feature macro: RESULT_SIGNED_EN (adds the neg signal).
interface result_bcd_conv_if;
  import minialu_pkg::*;

  logic    in_valid;
  logic    in_ready;
  result_t result;
  logic    out_valid;
  logic    out_ready;
  bcd_t    bcd;
`ifdef RESULT_SIGNED_EN
  logic    neg;
`endif
  logic    busy;

`ifdef RESULT_SIGNED_EN
  modport master (
    output in_valid, result, out_ready,
    input  in_ready, out_valid, bcd, neg, busy
  );
  modport slave (
    input  in_valid, result, out_ready,
    output in_ready, out_valid, bcd, neg, busy
  );
`else
  modport master (
    output in_valid, result, out_ready,
    input  in_ready, out_valid, bcd, busy
  );
  modport slave (
    input  in_valid, result, out_ready,
    output in_ready, out_valid, bcd, busy
  );
`endif

endinterface

// File: rtl/bcd_add3.sv
// Combinational single-digit double-dabble corrector (in >= 5 -> in + 3).
module bcd_add3
  import minialu_pkg::*;
(
  input  digit_t i_digit,
  output digit_t o_digit
);

  assign o_digit = add3_if_ge5(i_digit);

endmodule

// File: rtl/result_bcd_conv.sv
// result_bcd_conv: sequential double-dabble conversion of a 20-bit miniALU
// result into 7 packed BCD digits, one shift per clock (20 shift cycles).
// Optional feature macro: RESULT_SIGNED_EN -- input is two's complement,
// the magnitude is converted and the sign is reported on neg.
module result_bcd_conv
  import minialu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  result_bcd_conv_if.slave bus
);

  state_t  r_state;
  state_t  w_state_nxt;
  cnt_t    r_cnt;
  bcd_t    r_bcd;
  result_t r_mag;
  result_t w_mag;
  bcd_t    w_bcd_adj;
  logic    w_accept;
  logic    w_last;
`ifdef RESULT_SIGNED_EN
  logic    r_neg;
`endif

  digit_t  w_digit [BCD_DIGITS];
  digit_t  w_adj   [BCD_DIGITS];

  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_last   = (r_cnt == LAST_SHIFT);

  // Magnitude to convert; |0x80000| wraps to 0x80000, which is 524288 unsigned.
`ifdef RESULT_SIGNED_EN
  assign w_mag = bus.result[RESULT_W-1] ? (-bus.result) : bus.result;
`else
  assign w_mag = bus.result;
`endif

  // One corrector per BCD digit, applied before every shift.
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
    assign w_digit[g] = r_bcd[4*g +: 4];

    bcd_add3 u_add3 (
      .i_digit (w_digit[g]),
      .o_digit (w_adj[g])
    );

    assign w_bcd_adj[4*g +: 4] = w_adj[g];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      // NOTE: clocked state uses <= so every register samples pre-edge values.
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.in_valid)  w_state_nxt = SHIFT;
      SHIFT:   if (w_last)        w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  // Handshake/status outputs decoded purely from the current state.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (r_state)
      IDLE:    bus.in_ready  = 1'b1;
      SHIFT:   bus.busy      = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Conversion datapath: load on accept, correct-and-shift in SHIFT, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset as well, because bcd/neg are
      // directly visible outputs that must read 0 while reset is asserted.
      r_bcd <= '0;
      r_mag <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_bcd <= '0;
      r_mag <= w_mag;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      {r_bcd, r_mag} <= {w_bcd_adj[BCD_W-2:0], r_mag, 1'b0};
      r_cnt          <= r_cnt + cnt_t'(1);
    end
  end

`ifdef RESULT_SIGNED_EN
  // Sign flag captured alongside the magnitude; holds through SHIFT and DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg <= 1'b0;
    end else if (w_accept) begin
      r_neg <= bus.result[RESULT_W-1];
    end
  end

  assign bus.neg = r_neg;
`endif

  assign bus.bcd = r_bcd;

endmodule

// File: doc/result_bcd_conv.md
RESULT_BCD_CONV -- requirements
Module: result_bcd_conv

Interface
REQ-001 The module SHALL have no parameters; all widths SHALL come from package constants RESULT_W = 20 and BCD_DIGITS = 7.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  the miniALU result is presented.
REQ-005 in_ready  output  1  the block accepts a result.
REQ-006 result  input  20  the miniALU result word.
REQ-007 out_valid  output  1  the BCD result is available.
REQ-008 out_ready  input  1  the consumer takes the BCD result.
REQ-009 bcd  output  28  7 BCD digits; digit 0 SHALL be in bits [3:0] (least significant).
REQ-010 neg  output  1  the result was negative; this port exists only when signed mode is compiled in.
REQ-011 busy  output  1  a conversion is in progress.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; busy SHALL be 1 only in SHIFT.
REQ-014 On an accept edge (IDLE with in_valid=1), the block SHALL capture the magnitude of result, clear the BCD register, clear the 5-bit shift counter and go to SHIFT.
REQ-015 On each SHIFT cycle, the block SHALL add 3 to every digit ≥5, then shift the {bcd, magnitude} register left by 1.
REQ-016 After 20 shifts (counter = 19), the block SHALL go to DONE on that same edge, so out_valid rises on the 20th edge after the accept edge.
REQ-017 In DONE, bcd and neg SHALL hold stable until an edge with out_ready=1, which SHALL return the FSM to IDLE.
REQ-018 in_valid SHALL be ignored outside IDLE, giving a minimum of 22 cycles per conversion.
REQ-019 out_ready SHALL be ignored outside DONE.
REQ-020 A result of 0 SHALL yield bcd = 0 and neg = 0.
REQ-021 Unused upper digits SHALL be 0.

Reset
REQ-022 Reset asserted SHALL force IDLE, bcd = 0, neg = 0, out_valid = 0, busy = 0, counter = 0 and in_ready = 1, including when asserted mid-SHIFT or in DONE.
REQ-023 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-024 With RESULT_SIGNED_EN defined, result SHALL be two's complement: magnitude = |result|, neg = result[19], and 0x80000 SHALL convert to 524288 with neg = 1.
REQ-025 Without RESULT_SIGNED_EN, result SHALL be unsigned (0..1048575), the neg port SHALL be absent, and the magnitude SHALL be result.

Structure
REQ-026 Package minialu_pkg SHALL hold RESULT_W, BCD_DIGITS, the state enum type and the digit typedef (logic [3:0]).
REQ-027 Sub-module bcd_add3 SHALL be a combinational single-digit corrector (in ≥5 → in+3), instantiated BCD_DIGITS times.

Verification
REQ-028 result = 0x00014 (10+10) accepted -> out_valid on the 20th edge; bcd = 0x0000020, neg = 0.
REQ-029 Signed build: result = 0xFFFFF (10−11) -> bcd = 0x0000001, neg = 1. Unsigned build: the same input -> bcd = 0x1048575.
REQ-030 Signed build: result = 0x80000 -> bcd = 0x0524288, neg = 1. result = 0x7FFFF -> bcd = 0x0524287, neg = 0.
REQ-031 out_ready held 0 for 5 cycles in DONE -> out_valid and bcd stable, in_ready = 0. Then out_ready = 1 -> IDLE next edge. A new in_valid presented during SHIFT is not accepted.
REQ-032 rst_n pulsed low at shift 10 -> outputs immediately 0, in_ready = 1. Next conversion of result = 0x00280 (10<<6) -> bcd = 0x0000640.
REQ-033 Back-to-back: in_valid and out_ready held 1 with result values 5 then 9 -> bcd 0x0000005 then 0x0000009, accepts exactly 22 cycles apart.
